// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch/retire loop: data word, sequencer state and wait counter.
// Also holds the data-strobe decode used while a load or store is in flight.
package fetch_sequencer_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        DATA   = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

    localparam int unsigned WAIT_W = 8;
    typedef logic [WAIT_W-1:0] wait_cnt_t;

    // Returns {dREN, dWEN}; a store wins when both request lines are high.
    function automatic logic [1:0] data_strobes(input logic ren_req, input logic wen_req);
        data_strobes = {ren_req & ~wen_req, wen_req};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the PC, instruction/data memory and control_unit signals around the fetch sequencer.
// The master modport is the sequencer's view; slave is the surrounding core/memory view.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    word_t pc;
    word_t iload;
    logic  ihit;
    logic  dhit;
    logic  dmemREN_req;
    logic  dmemWEN_req;
    logic  stall;
    logic  halt;
    logic  iREN;
    word_t iaddr;
    logic  dREN;
    logic  dWEN;
    word_t instr;
    logic  instr_valid;
    logic  pc_en;
    logic  halted;
    logic  fetch_err;

    modport master (
        input  pc, iload, ihit, dhit, dmemREN_req, dmemWEN_req, stall, halt,
        output iREN, iaddr, dREN, dWEN, instr, instr_valid, pc_en, halted, fetch_err
    );

    modport slave (
        output pc, iload, ihit, dhit, dmemREN_req, dmemWEN_req, stall, halt,
        input  iREN, iaddr, dREN, dWEN, instr, instr_valid, pc_en, halted, fetch_err
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/data/retire sequencer of the single-issue core.
// Memory strobes and pc_en decode directly from state so reset drops them asynchronously.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter word_t       NOP_WORD   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    fetch_sequencer_if.master fif
);

    localparam wait_cnt_t WAIT_LIM_C = wait_cnt_t'(WAIT_LIMIT);

    fetch_state_t state_r;
    fetch_state_t next_state_s;
    word_t        instr_r;
    logic         instr_valid_r;
    logic         halted_r;
    logic         fetch_err_r;
    wait_cnt_t    wait_cnt_r;

    logic         iren_s;
    logic         dren_s;
    logic         dwen_s;
    logic         pc_en_s;
    logic         waiting_s;

    // Next-state decode and memory/retire strobes.
    always_comb begin
        next_state_s = state_r;
        iren_s       = 1'b0;
        dren_s       = 1'b0;
        dwen_s       = 1'b0;
        pc_en_s      = 1'b0;
        waiting_s    = 1'b0;
        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end
            FETCH: begin
                iren_s = 1'b1;
                if (fif.ihit) begin
                    next_state_s = HOLD;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            HOLD: begin
                if (fif.halt) begin
                    next_state_s = HALTED;
                end else if (fif.dmemREN_req || fif.dmemWEN_req) begin
                    next_state_s = DATA;
                end else if (!fif.stall) begin
                    pc_en_s      = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = HOLD;
                end
            end
            DATA: begin
                {dren_s, dwen_s} = data_strobes(fif.dmemREN_req, fif.dmemWEN_req);
                // Retire from DATA ignores stall: the access has already completed.
                if (fif.dhit) begin
                    pc_en_s      = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            HALTED: begin
                next_state_s = HALTED;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, decode register, status flags and the memory wait counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r       <= IDLE;
            instr_r       <= NOP_WORD;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            fetch_err_r   <= 1'b0;
            wait_cnt_r    <= '0;
        end else begin
            state_r <= next_state_s;

            if (state_r == FETCH && fif.ihit) begin
                instr_r       <= fif.iload;
                instr_valid_r <= 1'b1;
            end else if (pc_en_s || next_state_s == HALTED) begin
                instr_valid_r <= 1'b0;
            end

            if (next_state_s == HALTED) begin
                halted_r <= 1'b1;
            end

            // Timeout only flags the problem; the access keeps waiting.
            if (waiting_s) begin
                if (wait_cnt_r < WAIT_LIM_C) begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                end
                if (wait_cnt_r >= WAIT_LIM_C - 8'd1) begin
                    fetch_err_r <= 1'b1;
                end
            end else begin
                wait_cnt_r <= '0;
            end
        end
    end

    assign fif.iREN        = iren_s;
    assign fif.dREN        = dren_s;
    assign fif.dWEN        = dwen_s;
    assign fif.pc_en       = pc_en_s;
    assign fif.iaddr       = fif.pc;
    assign fif.instr       = instr_r;
    assign fif.instr_valid = instr_valid_r;
    assign fif.halted      = halted_r;
    assign fif.fetch_err   = fetch_err_r;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sits between program_counter and the instruction/data memory interface, and feeds control_unit with the current instruction. Issues instruction fetches at the PC address and latches the returned word into a decode register. Sequences any data access requested by the decoded instruction, then pulses pc_en to retire the instruction and advance the PC. Forms the multi-cycle fetch/retire loop of the single-issue core.

Parameters:
NOP_WORD, 32'h0000_0000, value held in instr when no valid instruction is present
WAIT_LIMIT, 255, cycles without ihit/dhit before fetch_err sets; range 1..255

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
pc  in  32  current PC from program_counter
iload  in  32  instruction word from memory
ihit  in  1  instruction memory response valid
dhit  in  1  data memory response valid
dmemREN_req  in  1  control_unit decode: instruction is a load
dmemWEN_req  in  1  control_unit decode: instruction is a store
stall  in  1  downstream hazard; blocks retire
halt  in  1  control_unit decode: HALT instruction
iREN  out  1  instruction read enable
iaddr  out  32  instruction address
dREN  out  1  data read enable
dWEN  out  1  data write enable
instr  out  32  latched instruction to control_unit
instr_valid  out  1  instr holds a fetched, unretired instruction
pc_en  out  1  one-cycle retire pulse to program_counter
halted  out  1  core halted
fetch_err  out  1  sticky memory-timeout flag

Behaviour:
- One clock CLK; reset nRST is asynchronous, active-low.
- Reset state: state=IDLE, instr=NOP_WORD, instr_valid=0, halted=0, fetch_err=0, wait counter=0. All strobes (iREN, dREN, dWEN, pc_en) are combinational decodes of state, so they are 0 while nRST=0.
- iaddr=pc at all times (combinational).
- States:
  - IDLE -> FETCH unconditionally on the first clock after reset release.
  - FETCH: iREN=1. On ihit: instr<=iload, instr_valid<=1, go to HOLD.
  - HOLD: decode cycle, no memory strobes.
    - halt=1 -> HALTED (priority over everything else).
    - Else dmemREN_req|dmemWEN_req -> DATA.
    - Else stall=0 -> pc_en=1 this cycle, instr_valid<=0, go to FETCH.
    - Else (stall=1) stay in HOLD; instr held.
  - DATA: dREN=dmemREN_req, dWEN=dmemWEN_req; both held until dhit.
    - On dhit: strobes drop the next cycle, pc_en=1 this cycle, instr_valid<=0, go to FETCH.
    - stall does not delay retire from DATA.
    - Both req lines high: dWEN only; store wins.
  - HALTED: all strobes 0, halted=1, instr_valid=0. Only nRST exits.
- Latency:
  - Non-memory instruction with immediate ihit: 2 cycles/instruction.
  - Memory instruction: 2 + data-wait cycles.
  - pc_en is never high for two consecutive cycles.
- ihit outside FETCH and dhit outside DATA are ignored. Simultaneous ihit+dhit: only the one matching the current state counts.
- instr is updated only on ihit in FETCH.
- Wait counter (8 bits):
  - Increments each cycle in FETCH without ihit, or in DATA without dhit.
  - Clears on the accepting hit and on every state change.
  - On reaching WAIT_LIMIT, fetch_err<=1 (sticky until reset) and the counter saturates.
  - The FSM keeps waiting; the timeout does not abort the access.
- Reset mid-access: all strobes drop asynchronously; any in-flight response after release is ignored, because the FSM is in IDLE.

Decomposition:
- cpu_types_pkg: add fetch_state_t enum (IDLE, FETCH, HOLD, DATA, HALTED). Reuse word_t for pc, iaddr, iload and instr.
- No sub-module. Wait counter and FSM live in one always_ff; strobes come from one always_comb.
- New interface fetch_if.vh bundling the ports above, matching pc_if and control_unit_if style.

Test Plan:
1. nRST=0 mid-run -> all strobes 0 immediately, instr=0, instr_valid=0. Release -> iREN=1 on the second cycle, iaddr equals pc=0x0000_0040.
2. In FETCH, ihit=1 with iload={RTYPE,5'h0,5'h1,5'hA,5'h0,SUB}, no req -> next cycle instr=that word and instr_valid=1, pc_en=1 for exactly one cycle, then iREN=1 again.
3. LW fetched, dmemREN_req=1 in HOLD, dhit after 3 cycles -> dREN=1 for 3 cycles, iREN=0 throughout. pc_en pulses in the dhit cycle; dREN=0 the next cycle.
4. Non-memory instruction, stall=1 held 4 cycles in HOLD -> pc_en=0, instr stable. Stall drops -> pc_en=1 in that cycle.
5. halt=1 in HOLD -> halted=1 and stays, iREN/dREN/dWEN/pc_en=0. ihit pulses ignored; nRST clears halted.
6. WAIT_LIMIT=8, ihit held 0 -> fetch_err=1 after 8 FETCH cycles and stays 1 after a later ihit. Both req lines set -> dWEN=1, dREN=0.
